// File: rtl/i2c_apb_regs.sv
// APB register front-end for i2c_controller: TX/RX byte FIFOs, a per-byte
// launch sequencer and sticky status bits feeding a level interrupt.
module i2c_apb_regs #(
  parameter int FIFO_DEPTH = 4,
  parameter int RDLEN_W    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [4:0]  paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  output logic        irq,
  output logic        ctrl_enable,
  output logic [6:0]  ctrl_slave_address,
  output logic [7:0]  ctrl_data_in,
  output logic        ctrl_rw,
  output logic        ctrl_repeated_start,
  input  logic        ctrl_busy,
  input  logic        ctrl_done,
  input  logic        ctrl_ack_err,
  input  logic [7:0]  ctrl_data_out
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PULSE, S_WAIT} state_t;
  state_t state;

  logic [RDLEN_W-1:0] cfg_len, xfer_len, byte_cnt;
  logic               cfg_rw, cfg_rs, cfg_irq_en;
  logic [6:0]         cfg_addr;
  logic               sticky_nack, sticky_done, sticky_ovr;
  logic [7:0]         tx_mem [FIFO_DEPTH];
  logic [7:0]         rx_mem [FIFO_DEPTH];
  logic [PW-1:0]      tx_wptr, tx_rptr, rx_wptr, rx_rptr;

  function automatic logic fifo_empty(input logic [PW-1:0] w, input logic [PW-1:0] r);
    return w == r;
  endfunction

  function automatic logic fifo_full(input logic [PW-1:0] w, input logic [PW-1:0] r);
    return (w[AW] != r[AW]) && (w[AW-1:0] == r[AW-1:0]);
  endfunction

  logic acc, wr, rd, aligned, mapped;
  logic sel_ctrl, sel_addr, sel_tx, sel_rx, sel_stat;
  logic tx_empty, tx_full, rx_empty, rx_full;
  logic launch, tx_push_req, tx_push, tx_pop, rx_push_req, rx_push, rx_pop;
  logic byte_end, last_rd, nack_set, done_set, ovr_set;
  logic [2:0] w1c;
  logic unused_pwdata;

  assign acc      = psel & penable;
  assign wr       = acc & pwrite;
  assign rd       = acc & ~pwrite;
  assign aligned  = (paddr[1:0] == 2'b00);
  assign sel_ctrl = aligned & (paddr[4:2] == 3'd0);
  assign sel_addr = aligned & (paddr[4:2] == 3'd1);
  assign sel_tx   = aligned & (paddr[4:2] == 3'd2);
  assign sel_rx   = aligned & (paddr[4:2] == 3'd3);
  assign sel_stat = aligned & (paddr[4:2] == 3'd4);
  assign mapped   = sel_ctrl | sel_addr | sel_tx | sel_rx | sel_stat;

  assign tx_empty = fifo_empty(tx_wptr, tx_rptr);
  assign tx_full  = fifo_full(tx_wptr, tx_rptr);
  assign rx_empty = fifo_empty(rx_wptr, rx_rptr);
  assign rx_full  = fifo_full(rx_wptr, rx_rptr);

  // A start is only honoured from IDLE with an idle controller, and a write
  // start needs at least one queued byte.
  assign launch      = wr & sel_ctrl & pwdata[0] & (state == S_IDLE) & ~ctrl_busy
                     & (pwdata[1] | ~tx_empty);
  assign tx_push_req = wr & sel_tx;
  assign tx_push     = tx_push_req & ~tx_full;
  assign tx_pop      = (state == S_LOAD) & ~cfg_rw & ~tx_empty;
  assign byte_end    = (state == S_WAIT) & ctrl_done;
  assign rx_push_req = byte_end & ~ctrl_ack_err & ctrl_rw;
  assign rx_push     = rx_push_req & ~rx_full;
  assign rx_pop      = rd & sel_rx & ~rx_empty;
  assign last_rd     = (byte_cnt == xfer_len);
  assign nack_set    = byte_end & ctrl_ack_err;
  assign done_set    = byte_end & ~ctrl_ack_err & (ctrl_rw ? last_rd : tx_empty);
  assign ovr_set     = (tx_push_req & tx_full) | (rx_push_req & rx_full);
  assign w1c         = (wr & sel_stat) ? pwdata[7:5] : 3'b000;

  assign pready        = 1'b1;
  assign pslverr       = acc & ~mapped;
  assign irq           = cfg_irq_en & (sticky_done | sticky_nack | sticky_ovr);
  assign unused_pwdata = ^pwdata[31:8+RDLEN_W];

  // Software-visible configuration registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_rw     <= 1'b0;
      cfg_rs     <= 1'b0;
      cfg_irq_en <= 1'b0;
      cfg_len    <= '0;
      cfg_addr   <= '0;
    end else begin
      if (wr & sel_ctrl) begin
        cfg_rw     <= pwdata[1];
        cfg_rs     <= pwdata[2];
        cfg_irq_en <= pwdata[3];
        cfg_len    <= pwdata[8 +: RDLEN_W];
      end
      if (wr & sel_addr) cfg_addr <= pwdata[6:0];
    end
  end

  // TX FIFO: filled from APB, drained by the sequencer in LOAD
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wptr <= '0;
      tx_rptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) tx_mem[i] <= '0;
    end else begin
      if (tx_push) begin
        tx_mem[tx_wptr[AW-1:0]] <= pwdata[7:0];
        tx_wptr                 <= tx_wptr + 1'b1;
      end
      if (tx_pop) tx_rptr <= tx_rptr + 1'b1;
    end
  end

  // RX FIFO: filled from the controller, drained by RXDATA reads
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wptr <= '0;
      rx_rptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) rx_mem[i] <= '0;
    end else begin
      if (rx_push) begin
        rx_mem[rx_wptr[AW-1:0]] <= ctrl_data_out;
        rx_wptr                 <= rx_wptr + 1'b1;
      end
      if (rx_pop) rx_rptr <= rx_rptr + 1'b1;
    end
  end

  // Sticky status; a hardware set beats a same-cycle write-one-to-clear
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_nack <= 1'b0;
      sticky_done <= 1'b0;
      sticky_ovr  <= 1'b0;
    end else begin
      sticky_nack <= (sticky_nack & ~w1c[0]) | nack_set;
      sticky_done <= (sticky_done & ~w1c[1]) | done_set;
      sticky_ovr  <= (sticky_ovr  & ~w1c[2]) | ovr_set;
    end
  end

  // Byte sequencer: one launch per byte, controller outputs held until done
  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= S_IDLE;
      ctrl_enable         <= 1'b0;
      ctrl_slave_address  <= '0;
      ctrl_data_in        <= '0;
      ctrl_rw             <= 1'b0;
      ctrl_repeated_start <= 1'b0;
      byte_cnt            <= '0;
      xfer_len            <= '0;
    end else begin
      ctrl_enable <= 1'b0;
      case (state)
        S_IDLE: begin
          if (launch) begin
            state    <= S_LOAD;
            byte_cnt <= '0;
            xfer_len <= pwdata[8 +: RDLEN_W];
          end
        end
        S_LOAD: begin
          ctrl_slave_address  <= cfg_addr;
          ctrl_rw             <= cfg_rw;
          ctrl_repeated_start <= cfg_rs;
          if (tx_pop) ctrl_data_in <= tx_mem[tx_rptr[AW-1:0]];
          state <= S_PULSE;
        end
        S_PULSE: begin
          ctrl_enable <= 1'b1;
          state       <= S_WAIT;
        end
        S_WAIT: begin
          if (ctrl_done) begin
            if (ctrl_ack_err) begin
              state <= S_IDLE;
            end else if (ctrl_rw) begin
              if (last_rd) begin
                state <= S_IDLE;
              end else begin
                byte_cnt <= byte_cnt + 1'b1;
                state    <= S_PULSE;
              end
            end else begin
              state <= tx_empty ? S_IDLE : S_LOAD;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // APB read mux, live during the access phase
  always_comb begin
    prdata = '0;
    if (acc) begin
      if (sel_ctrl) begin
        prdata[1]             = cfg_rw;
        prdata[2]             = cfg_rs;
        prdata[3]             = cfg_irq_en;
        prdata[8 +: RDLEN_W]  = cfg_len;
      end
      if (sel_addr) prdata[6:0] = cfg_addr;
      if (sel_rx && !rx_empty) prdata[7:0] = rx_mem[rx_rptr[AW-1:0]];
      if (sel_stat) prdata[7:0] = {sticky_ovr, sticky_done, sticky_nack, rx_empty,
                                   rx_full, tx_empty, tx_full, (state != S_IDLE)};
    end
  end
endmodule

// File: tb/tb_i2c_apb_regs.sv
// Bench for i2c_apb_regs: a queue-based transaction model predicts launches,
// FIFO contents and sticky status; a bus-functional controller answers launches.
module tb_i2c_apb_regs;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        psel, penable, pwrite;
  logic [4:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready, pslverr, irq;
  logic        ctrl_enable, ctrl_rw, ctrl_repeated_start;
  logic [6:0]  ctrl_slave_address;
  logic [7:0]  ctrl_data_in;
  logic        ctrl_busy, ctrl_done, ctrl_ack_err;
  logic [7:0]  ctrl_data_out;

  logic resp_busy = 1'b0;
  logic tb_busy   = 1'b0;
  assign ctrl_busy = resp_busy | tb_busy;

  i2c_apb_regs #(.FIFO_DEPTH(DEPTH), .RDLEN_W(4)) dut (
    .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .irq(irq), .ctrl_enable(ctrl_enable),
    .ctrl_slave_address(ctrl_slave_address), .ctrl_data_in(ctrl_data_in),
    .ctrl_rw(ctrl_rw), .ctrl_repeated_start(ctrl_repeated_start),
    .ctrl_busy(ctrl_busy), .ctrl_done(ctrl_done), .ctrl_ack_err(ctrl_ack_err),
    .ctrl_data_out(ctrl_data_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed { logic [6:0] addr; logic [7:0] data; logic rw; logic rs; } launch_t;
  typedef struct packed { logic ack; logic [7:0] data; } resp_t;

  // Behavioural model state
  logic [7:0] m_tx[$];
  logic [7:0] m_rx[$];
  logic       m_nack, m_done, m_ovr, m_irq_en;
  logic [6:0] m_addr;
  launch_t    exp_q[$];
  resp_t      resp_q[$];
  logic       plan_ack [16];
  logic [7:0] plan_data [16];

  int   n_tests = 0;
  int   n_fail  = 0;
  logic settled = 1'b0;
  logic abort_flag = 1'b0;
  logic resp_long = 1'b0;
  logic first_pend = 1'b0;
  int   start_cyc = 0;
  logic prev_en = 1'b0;
  launch_t last_l = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] m_status();
    return {m_ovr, m_done, m_nack, m_rx.size() == 0, m_rx.size() == DEPTH,
            m_tx.size() == 0, m_tx.size() == DEPTH, 1'b0};
  endfunction

  task automatic model_reset();
    m_tx.delete(); m_rx.delete(); exp_q.delete(); resp_q.delete();
    m_nack = 0; m_done = 0; m_ovr = 0; m_irq_en = 0; m_addr = '0;
  endtask

  task automatic apb_write(input logic [4:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    psel = 1; penable = 0; pwrite = 1; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1;
    @(posedge clk); #1;
    psel = 0; penable = 0; pwrite = 0;
  endtask

  task automatic apb_read(input logic [4:0] a, output logic [31:0] d, output logic e);
    @(posedge clk); #1;
    psel = 1; penable = 0; pwrite = 0; paddr = a;
    @(posedge clk); #1;
    penable = 1;
    @(negedge clk);
    d = prdata; e = pslverr;
    @(posedge clk); #1;
    psel = 0; penable = 0;
  endtask

  task automatic tx_push(input logic [7:0] b);
    apb_write(5'h08, {24'b0, b});
    if (m_tx.size() < DEPTH) m_tx.push_back(b); else m_ovr = 1;
  endtask

  task automatic w1c(input logic [7:0] bits);
    apb_write(5'h10, {24'b0, bits});
    if (bits[5]) m_nack = 0;
    if (bits[6]) m_done = 0;
    if (bits[7]) m_ovr = 0;
  endtask

  task automatic set_addr(input logic [6:0] a);
    apb_write(5'h04, {25'b0, a});
    m_addr = a;
  endtask

  task automatic status_chk(input string nm);
    logic [31:0] d; logic e;
    apb_read(5'h10, d, e);
    chk(nm, d, {24'b0, m_status()});
    chk({nm, "_slverr"}, e, 0);
  endtask

  task automatic st_lit(input string nm, input logic [7:0] lit);
    logic [31:0] d; logic e;
    apb_read(5'h10, d, e);
    chk(nm, d, {24'b0, lit});
    chk({nm, "_model"}, {24'b0, m_status()}, {24'b0, lit});
  endtask

  task automatic rx_read(output logic [31:0] d);
    logic e; logic [31:0] exp;
    apb_read(5'h0C, d, e);
    exp = (m_rx.size() != 0) ? {24'b0, m_rx[0]} : 32'h0;
    chk("rxdata", d, exp);
    chk("rxdata_slverr", e, 0);
    if (m_rx.size() != 0) void'(m_rx.pop_front());
  endtask

  // Predict the whole transfer from the planned controller responses, then
  // issue the start and wait for the controller side to go quiet.
  task automatic do_start(input logic rw, input logic rs, input logic ien,
                          input int len, input logic ext_busy);
    logic accepted, pend;
    m_irq_en = ien;
    accepted = !ext_busy && !(rw == 0 && m_tx.size() == 0);
    if (accepted) begin
      if (!rw) begin
        for (int i = 0; i < 16; i++) begin
          logic [7:0] b;
          b = m_tx.pop_front();
          exp_q.push_back(launch_t'{m_addr, b, 1'b0, rs});
          resp_q.push_back(resp_t'{plan_ack[i], plan_data[i]});
          if (plan_ack[i]) begin m_nack = 1; break; end
          if (m_tx.size() == 0) begin m_done = 1; break; end
        end
      end else begin
        for (int i = 0; i <= len; i++) begin
          exp_q.push_back(launch_t'{m_addr, 8'h00, 1'b1, rs});
          resp_q.push_back(resp_t'{plan_ack[i], plan_data[i]});
          if (plan_ack[i]) begin m_nack = 1; break; end
          if (m_rx.size() < DEPTH) m_rx.push_back(plan_data[i]); else m_ovr = 1;
          if (i == len) m_done = 1;
        end
      end
    end
    settled = 0;
    tb_busy = ext_busy;
    apb_write(5'h00, {20'b0, 4'(len), 4'b0, ien, rs, rw, 1'b1});
    start_cyc  = cyc;
    first_pend = accepted;
    pend = 1;
    for (int k = 0; k < 400 && pend; k++) begin
      @(posedge clk); #2;
      pend = (exp_q.size() != 0) || (resp_q.size() != 0) || resp_busy;
    end
    chk("xfer_complete", pend, 0);
    repeat (6) @(posedge clk);
    #1;
    tb_busy = 0;
    settled = 1;
  endtask

  // Controller stand-in: answers each launch after a short random delay
  initial begin
    resp_t r;
    int dly;
    logic aborted;
    ctrl_done = 0; ctrl_ack_err = 0; ctrl_data_out = 0;
    forever begin
      @(negedge clk);
      if (ctrl_enable === 1'b1 && !rst) begin
        resp_busy = 1;
        r = (resp_q.size() > 0) ? resp_q.pop_front() : '0;
        dly = resp_long ? 20 : $urandom_range(1, 3);
        aborted = 0;
        for (int k = 0; k < dly; k++) begin
          @(posedge clk);
          if (rst) begin aborted = 1; break; end
        end
        #1;
        if (!aborted && !rst) begin
          ctrl_done = 1; ctrl_ack_err = r.ack; ctrl_data_out = r.data;
          @(posedge clk); #1;
          ctrl_done = 0; ctrl_ack_err = 0;
        end
        resp_busy = 0;
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (!rst) begin
      chk("pready", pready, 1);
      if (ctrl_enable) begin
        chk("enable_width", prev_en, 0);
        if (exp_q.size() == 0) begin
          chk("unexpected_enable", ctrl_enable, 0);
        end else begin
          last_l = exp_q.pop_front();
          chk("launch_addr", ctrl_slave_address, last_l.addr);
          chk("launch_rw", ctrl_rw, last_l.rw);
          chk("launch_rs", ctrl_repeated_start, last_l.rs);
          if (!last_l.rw) chk("launch_data", ctrl_data_in, last_l.data);
          if (first_pend) begin
            chk("launch_latency", cyc, start_cyc + 2);
            first_pend = 0;
          end
        end
      end else if (resp_busy && !abort_flag) begin
        chk("hold_addr", ctrl_slave_address, last_l.addr);
        if (!last_l.rw) chk("hold_data", ctrl_data_in, last_l.data);
      end
      if (settled) chk("irq", irq, m_irq_en & (m_done | m_nack | m_ovr));
    end
    prev_en = ctrl_enable;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic e, pend;
    rst = 1; psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0;
    model_reset();
    for (int i = 0; i < 16; i++) begin plan_ack[i] = 0; plan_data[i] = 0; end
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("reset_enable", ctrl_enable, 0);
    chk("reset_irq", irq, 0);
    settled = 1;
    st_lit("reset_status", 8'h14);

    // Single write byte
    set_addr(7'h6B);
    tx_push(8'hAA);
    do_start(0, 0, 0, 0, 0);
    chk("t1_addr_lit", ctrl_slave_address, 7'h6B);
    chk("t1_data_lit", ctrl_data_in, 8'hAA);
    chk("t1_rw_lit", ctrl_rw, 0);
    st_lit("t1_status", 8'h54);

    // Three write bytes in FIFO order
    w1c(8'h40);
    st_lit("t2_cleared", 8'h14);
    tx_push(8'h11); tx_push(8'h22); tx_push(8'h33);
    do_start(0, 1, 0, 0, 0);
    chk("t2_last_data_lit", ctrl_data_in, 8'h33);
    st_lit("t2_status", 8'h54);

    // Two-byte read
    w1c(8'h40);
    plan_data[0] = 8'h12; plan_data[1] = 8'h34;
    do_start(1, 0, 0, 1, 0);
    st_lit("t3_status", 8'h44);
    rx_read(d); chk("t3_rx0_lit", d, 32'h12);
    rx_read(d); chk("t3_rx1_lit", d, 32'h34);
    rx_read(d); chk("t3_rx2_lit", d, 32'h0);

    // NACK on first of two write bytes, with irq enabled
    w1c(8'h40);
    tx_push(8'h77); tx_push(8'h88);
    plan_ack[0] = 1;
    do_start(0, 0, 1, 0, 0);
    plan_ack[0] = 0;
    chk("t4_data_lit", ctrl_data_in, 8'h77);
    st_lit("t4_status", 8'h30);
    chk("t4_irq_lit", irq, 1);

    // Drain, then overfill TX
    do_start(0, 0, 1, 0, 0);
    st_lit("t5_drained", 8'h74);
    w1c(8'hE0);
    st_lit("t5_cleared", 8'h14);
    chk("t5_irq_low", irq, 0);
    for (int i = 0; i < 5; i++) tx_push(8'hC0 + 8'(i));
    st_lit("t5_overrun", 8'h92);
    chk("t5_irq_ovr", irq, 1);
    w1c(8'h80);
    st_lit("t5_ovr_clr", 8'h12);

    // Start ignored while the controller is busy, and write start with TX empty
    do_start(1, 0, 0, 0, 1);
    st_lit("t6_busy_ignored", 8'h12);
    do_start(0, 0, 0, 0, 0);
    st_lit("t6_drained", 8'h54);
    w1c(8'h40);
    do_start(0, 0, 0, 0, 0);
    st_lit("t6_empty_ignored", 8'h14);

    // Reset in the middle of a byte
    set_addr(7'h2A);
    tx_push(8'h5A); tx_push(8'hC3);
    exp_q.push_back(launch_t'{7'h2A, 8'h5A, 1'b0, 1'b0});
    resp_q.push_back(resp_t'{1'b0, 8'h00});
    resp_long = 1;
    settled = 0;
    apb_write(5'h00, 32'h1);
    start_cyc = cyc; first_pend = 1;
    pend = 1;
    for (int k = 0; k < 50 && pend; k++) begin @(posedge clk); #2; pend = !resp_busy; end
    chk("t7_launched", pend, 0);
    apb_read(5'h10, d, e);
    chk("t7_busy_bit", d[0], 1);
    abort_flag = 1;
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    chk("t7_rst_enable", ctrl_enable, 0);
    chk("t7_rst_addr", ctrl_slave_address, 0);
    chk("t7_rst_data", ctrl_data_in, 0);
    chk("t7_rst_rw", ctrl_rw, 0);
    chk("t7_rst_rs", ctrl_repeated_start, 0);
    chk("t7_rst_irq", irq, 0);
    rst = 0;
    model_reset();
    pend = 1;
    for (int k = 0; k < 50 && pend; k++) begin @(posedge clk); #2; pend = resp_busy; end
    chk("t7_resp_idle", pend, 0);
    resp_long = 0; abort_flag = 0; first_pend = 0;
    settled = 1;
    st_lit("t7_status", 8'h14);
    apb_read(5'h14, d, e);
    chk("t7_slverr_14", e, 1);
    chk("t7_rdata_14", d, 0);

    // Randomized transactions
    for (int it = 0; it < 40; it++) begin
      logic rw, rs, ien, bz;
      int len, n;
      if ($urandom_range(0, 3) == 0) w1c(8'($urandom_range(0, 7)) << 5);
      if ($urandom_range(0, 2) == 0) set_addr(7'($urandom));
      if ($urandom_range(0, 5) == 0) begin
        apb_read(5'h18 | 5'($urandom_range(0, 1) * 2), d, e);
        chk("rand_slverr", e, 1);
        apb_write(5'h1C, $urandom);
      end
      n = $urandom_range(0, 5);
      for (int i = 0; i < n; i++) tx_push(8'($urandom));
      rw  = 1'($urandom);
      rs  = 1'($urandom);
      ien = 1'($urandom);
      bz  = ($urandom_range(0, 7) == 0);
      len = $urandom_range(0, 5);
      for (int i = 0; i < 16; i++) begin
        plan_ack[i]  = ($urandom_range(0, 7) == 0);
        plan_data[i] = 8'($urandom);
      end
      do_start(rw, rs, ien, len, bz);
      status_chk("rand_status");
      n = $urandom_range(0, 3);
      for (int i = 0; i < n; i++) rx_read(d);
      status_chk("rand_status_post");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
